// File: rtl/axicb_slv_wr_sched_if.sv
// Bundle of the AW/W channels around the slave-side write scheduler.
// The "slave" modport is the scheduler's view. The "master" modport is the
// surrounding fabric: the requesters plus the downstream slave interface.
interface axicb_slv_wr_sched_if #(
  parameter int MST_NB  = 4,
  parameter int AWCH_W  = 8,
  parameter int WCH_W   = 8,
  parameter int OSTD_NB = 4
);
  logic [MST_NB-1:0]        i_awvalid;
  logic [MST_NB-1:0]        i_awready;
  logic [MST_NB*AWCH_W-1:0] i_awch;
  logic [MST_NB-1:0]        i_wvalid;
  logic [MST_NB-1:0]        i_wready;
  logic [MST_NB-1:0]        i_wlast;
  logic [MST_NB*WCH_W-1:0]  i_wch;
  logic                     o_awvalid;
  logic                     o_awready;
  logic [AWCH_W-1:0]        o_awch;
  logic                     o_wvalid;
  logic                     o_wready;
  logic                     o_wlast;
  logic [WCH_W-1:0]         o_wch;
  logic [$clog2(OSTD_NB):0] o_ostd_cnt;

  modport slave (
    input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, o_awready, o_wready,
    output i_awready, i_wready, o_awvalid, o_awch, o_wvalid, o_wlast, o_wch,
    output o_ostd_cnt
  );

  modport master (
    output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, o_awready, o_wready,
    input  i_awready, i_wready, o_awvalid, o_awch, o_wvalid, o_wlast, o_wch,
    input  o_ostd_cnt
  );
endinterface

// File: rtl/axicb_slv_wr_sched.sv
// Write-path scheduler for one crossbar slave port.
// AW requests are granted round-robin, and the grant is held stable while
// the slave stalls. The grant order is queued so that W bursts are
// forwarded in the same order as their addresses were accepted.
module axicb_slv_wr_sched #(
  parameter int MST_NB  = 4,
  parameter int AWCH_W  = 8,
  parameter int WCH_W   = 8,
  parameter int OSTD_NB = 4
) (
  input logic                   i_aclk,
  input logic                   i_arst,
  axicb_slv_wr_sched_if.slave   bus
);

  localparam int IDX_W = $clog2(MST_NB);
  localparam int PTR_W = $clog2(OSTD_NB);

  logic [IDX_W-1:0] prio_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic             lock;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             arb_found;
  logic [IDX_W-1:0] grant;
  logic             req;
  logic             full;
  logic             empty;
  logic             aw_hs;
  logic             w_pop;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] order_mem [OSTD_NB];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Round-robin search for the first active request, starting at the priority pointer
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_idx  = '0;
    for (int i = 0; i < MST_NB; i++) begin
      cand_idx = IDX_W'((int'(prio_ptr) + i) % MST_NB);
      if (!arb_found && bus.i_awvalid[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // A stalled grant stays locked so that the presented AW payload cannot change under valid
  assign grant = lock ? lock_idx : arb_idx;
  assign req   = lock | arb_found;
  assign full  = (count == (PTR_W+1)'(OSTD_NB));
  assign empty = (count == '0);
  assign aw_hs = bus.o_awvalid & bus.o_awready;

  assign bus.o_awvalid = req & ~full;
  assign bus.o_awch    = bus.i_awch[grant*AWCH_W +: AWCH_W];

  // Return ready only to the requester whose AW is being presented
  always_comb begin
    bus.i_awready = '0;
    if (req && !full && bus.o_awready) bus.i_awready[grant] = 1'b1;
  end

  // The W owner is whichever requester sits at the head of the order queue
  assign head           = order_mem[rd_ptr];
  assign bus.o_wvalid   = ~empty & bus.i_wvalid[head];
  assign bus.o_wlast    = ~empty & bus.i_wlast[head];
  assign bus.o_wch      = bus.i_wch[head*WCH_W +: WCH_W];
  assign bus.o_ostd_cnt = count;
  assign w_pop          = bus.o_wvalid & bus.o_wready & bus.o_wlast;

  // Forward the slave's W ready to the head requester only
  always_comb begin
    bus.i_wready = '0;
    if (!empty) bus.i_wready[head] = bus.o_wready;
  end

  // Priority pointer and AW lock follow the handshake outcome of each cycle
  always_ff @(posedge i_aclk or posedge i_arst) begin
    if (i_arst) begin
      prio_ptr <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (aw_hs) begin
      prio_ptr <= (grant == IDX_W'(MST_NB-1)) ? '0 : grant + 1'b1;
      lock     <= 1'b0;
    end else if (bus.o_awvalid) begin
      lock     <= 1'b1;
      lock_idx <= grant;
    end
  end

  // Order queue: push the granted index on each AW handshake, pop on the head's last W beat
  always_ff @(posedge i_aclk or posedge i_arst) begin
    if (i_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OSTD_NB; i++) order_mem[i] <= '0;
    end else begin
      if (aw_hs) begin
        order_mem[wr_ptr] <= grant;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (w_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({aw_hs, w_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_axicb_slv_wr_sched.sv
// Self-checking bench for axicb_slv_wr_sched: a vector table, directed
// corner-case sequences and a randomized run against a queue-based model.
module tb_axicb_slv_wr_sched;

  localparam int MST_NB  = 4;
  localparam int AWCH_W  = 8;
  localparam int WCH_W   = 8;
  localparam int OSTD_NB = 4;

  typedef struct {
    logic [3:0] awvalid;
    logic       awready;
    logic [3:0] wvalid;
    logic [3:0] wlast;
    logic       wready;
    logic       exp_awvalid;
    logic [3:0] exp_iawready;
    logic       exp_wvalid;
    logic [3:0] exp_iwready;
    logic [2:0] exp_cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  vec_t vecs [8];

  // Reference model state
  int   q[$];
  int   m_ptr;
  bit   m_lock;
  int   m_lock_idx;

  axicb_slv_wr_sched_if #(
    .MST_NB(MST_NB), .AWCH_W(AWCH_W), .WCH_W(WCH_W), .OSTD_NB(OSTD_NB)
  ) bus ();

  axicb_slv_wr_sched #(
    .MST_NB(MST_NB), .AWCH_W(AWCH_W), .WCH_W(WCH_W), .OSTD_NB(OSTD_NB)
  ) dut (
    .i_aclk (clk),
    .i_arst (rst),
    .bus    (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] awPay(int k);
    return 8'(8'hA0 + k);
  endfunction

  function automatic logic [7:0] wPay(int k);
    return 8'(8'hD0 + k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] awvalid, input logic awready,
                               input logic [3:0] wvalid, input logic [3:0] wlast,
                               input logic wready);
    bus.i_awvalid = awvalid;
    bus.o_awready = awready;
    bus.i_wvalid  = wvalid;
    bus.i_wlast   = wlast;
    bus.o_wready  = wready;
    bus.i_awch    = {awPay(3), awPay(2), awPay(1), awPay(0)};
    bus.i_wch     = {wPay(3), wPay(2), wPay(1), wPay(0)};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int oneHotIdx(logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return 0;
  endfunction

  // Main test sequence
  initial begin
    int   g;
    int   h;
    bit   found;
    bit   e_awvalid;
    bit   e_wvalid;
    bit   e_wlast;
    bit   aw_hs;
    bit   pop;
    logic [3:0] e_iar;
    logic [3:0] e_iwr;

    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    applyStimulus(4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset_awvalid", 32'(bus.o_awvalid), 32'd0);
    checkOutput("reset_wvalid", 32'(bus.o_wvalid), 32'd0);
    checkOutput("reset_cnt", 32'(bus.o_ostd_cnt), 32'd0);
    doReset();

    // Round-robin fill to full, then a pop with the refill one cycle later
    vecs[0] = '{4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 3'd0};
    vecs[1] = '{4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 4'h0, 3'd1};
    vecs[2] = '{4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 4'h4, 1'b0, 4'h0, 3'd2};
    vecs[3] = '{4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 4'h8, 1'b0, 4'h0, 3'd3};
    vecs[4] = '{4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 3'd4};
    vecs[5] = '{4'hF, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 4'h1, 3'd4};
    vecs[6] = '{4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 3'd3};
    vecs[7] = '{4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 3'd4};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].awvalid, vecs[i].awready, vecs[i].wvalid, vecs[i].wlast, vecs[i].wready);
      #2;
      checkOutput($sformatf("vec%0d_awvalid", i), 32'(bus.o_awvalid), 32'(vecs[i].exp_awvalid));
      checkOutput($sformatf("vec%0d_iawready", i), 32'(bus.i_awready), 32'(vecs[i].exp_iawready));
      checkOutput($sformatf("vec%0d_wvalid", i), 32'(bus.o_wvalid), 32'(vecs[i].exp_wvalid));
      checkOutput($sformatf("vec%0d_iwready", i), 32'(bus.i_wready), 32'(vecs[i].exp_iwready));
      checkOutput($sformatf("vec%0d_cnt", i), 32'(bus.o_ostd_cnt), 32'(vecs[i].exp_cnt));
      if (vecs[i].exp_awvalid)
        checkOutput($sformatf("vec%0d_awch", i), 32'(bus.o_awch), 32'(awPay(oneHotIdx(vecs[i].exp_iawready))));
      if (vecs[i].exp_wvalid)
        checkOutput($sformatf("vec%0d_wch", i), 32'(bus.o_wch), 32'(wPay(oneHotIdx(vecs[i].exp_iwready))));
      tick();
    end

    // Asynchronous reset in the middle of a cycle with a full queue
    applyStimulus(4'h0, 1'b1, 4'hF, 4'hF, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_awvalid", 32'(bus.o_awvalid), 32'd0);
    checkOutput("async_rst_wvalid", 32'(bus.o_wvalid), 32'd0);
    checkOutput("async_rst_iawready", 32'(bus.i_awready), 32'd0);
    checkOutput("async_rst_iwready", 32'(bus.i_wready), 32'd0);
    checkOutput("async_rst_cnt", 32'(bus.o_ostd_cnt), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(4'hF, 1'b1, 4'h0, 4'h0, 1'b0);
    #2;
    checkOutput("post_rst_grant", 32'(bus.i_awready), 32'h1);
    tick();

    // Stalled grant to 2 must hold while requester 0 joins
    doReset();
    applyStimulus(4'b0100, 1'b0, 4'h0, 4'h0, 1'b0);
    #2;
    checkOutput("stall_awvalid", 32'(bus.o_awvalid), 32'd1);
    checkOutput("stall_awch", 32'(bus.o_awch), 32'(awPay(2)));
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0101, 1'b0, 4'h0, 4'h0, 1'b0);
      #2;
      checkOutput($sformatf("stall%0d_awch", i), 32'(bus.o_awch), 32'(awPay(2)));
      checkOutput($sformatf("stall%0d_iawready", i), 32'(bus.i_awready), 32'h0);
      tick();
    end
    applyStimulus(4'b0101, 1'b1, 4'h0, 4'h0, 1'b0);
    #2;
    checkOutput("stall_release", 32'(bus.i_awready), 32'h4);
    tick();
    applyStimulus(4'b0001, 1'b1, 4'h0, 4'h0, 1'b0);
    #2;
    checkOutput("stall_next_grant", 32'(bus.i_awready), 32'h1);
    tick();

    // W ordering: AW 1 then 3; requester 3 must wait behind requester 1's burst
    doReset();
    applyStimulus(4'b0010, 1'b1, 4'h0, 4'h0, 1'b0);
    #2;
    checkOutput("ord_aw1", 32'(bus.i_awready), 32'h2);
    tick();
    applyStimulus(4'b1000, 1'b1, 4'b1000, 4'b0000, 1'b1);
    #2;
    checkOutput("ord_aw3", 32'(bus.i_awready), 32'h8);
    checkOutput("ord_w3_blocked", 32'(bus.i_wready), 32'h2);
    checkOutput("ord_no_wvalid", 32'(bus.o_wvalid), 32'd0);
    tick();
    applyStimulus(4'h0, 1'b1, 4'b1010, 4'b0000, 1'b1);
    #2;
    checkOutput("ord_b1_iwready", 32'(bus.i_wready), 32'h2);
    checkOutput("ord_b1_wch", 32'(bus.o_wch), 32'(wPay(1)));
    checkOutput("ord_cnt2", 32'(bus.o_ostd_cnt), 32'd2);
    tick();
    applyStimulus(4'h0, 1'b1, 4'b1010, 4'b0010, 1'b1);
    #2;
    checkOutput("ord_b1_last_iwready", 32'(bus.i_wready), 32'h2);
    checkOutput("ord_b1_wlast", 32'(bus.o_wlast), 32'd1);
    tick();
    applyStimulus(4'h0, 1'b1, 4'b1000, 4'b0000, 1'b1);
    #2;
    checkOutput("ord_b3_iwready", 32'(bus.i_wready), 32'h8);
    checkOutput("ord_b3_wch", 32'(bus.o_wch), 32'(wPay(3)));
    checkOutput("ord_cnt1", 32'(bus.o_ostd_cnt), 32'd1);
    tick();
    applyStimulus(4'h0, 1'b1, 4'b1000, 4'b1000, 1'b1);
    #2;
    checkOutput("ord_b3_last_iwready", 32'(bus.i_wready), 32'h8);
    tick();
    applyStimulus(4'h0, 1'b1, 4'h0, 4'h0, 1'b1);
    #2;
    checkOutput("ord_cnt0", 32'(bus.o_ostd_cnt), 32'd0);
    checkOutput("ord_idle_iwready", 32'(bus.i_wready), 32'h0);
    tick();

    // Back-to-back single-beat bursts from 0,1,0
    doReset();
    applyStimulus(4'b0001, 1'b1, 4'b0011, 4'b0011, 1'b1);
    #2;
    checkOutput("b2b_same_cycle_w", 32'(bus.o_wvalid), 32'd0);
    tick();
    applyStimulus(4'b0010, 1'b1, 4'b0011, 4'b0011, 1'b1);
    #2;
    checkOutput("b2b_w0_valid", 32'(bus.o_wvalid), 32'd1);
    checkOutput("b2b_w0_wch", 32'(bus.o_wch), 32'(wPay(0)));
    checkOutput("b2b_aw1", 32'(bus.i_awready), 32'h2);
    tick();
    applyStimulus(4'b0001, 1'b1, 4'b0011, 4'b0011, 1'b1);
    #2;
    checkOutput("b2b_w1_valid", 32'(bus.o_wvalid), 32'd1);
    checkOutput("b2b_w1_wch", 32'(bus.o_wch), 32'(wPay(1)));
    checkOutput("b2b_aw0", 32'(bus.i_awready), 32'h1);
    tick();
    applyStimulus(4'h0, 1'b1, 4'b0011, 4'b0011, 1'b1);
    #2;
    checkOutput("b2b_w2_valid", 32'(bus.o_wvalid), 32'd1);
    checkOutput("b2b_w2_wch", 32'(bus.o_wch), 32'(wPay(0)));
    checkOutput("b2b_w2_cnt", 32'(bus.o_ostd_cnt), 32'd1);
    tick();
    applyStimulus(4'h0, 1'b1, 4'b0011, 4'b0011, 1'b1);
    #2;
    checkOutput("b2b_drained", 32'(bus.o_wvalid), 32'd0);
    checkOutput("b2b_cnt0", 32'(bus.o_ostd_cnt), 32'd0);
    tick();

    // Randomized run against the queue-based reference model
    doReset();
    q.delete();
    m_ptr      = 0;
    m_lock     = 1'b0;
    m_lock_idx = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      applyStimulus(4'($urandom), ($urandom_range(0, 9) < 7), 4'($urandom), 4'($urandom),
                    ($urandom_range(0, 9) < 7));
      bus.i_awch = $urandom;
      bus.i_wch  = $urandom;
      #2;
      found = 1'b0;
      g     = 0;
      if (m_lock) begin
        found = 1'b1;
        g     = m_lock_idx;
      end else begin
        for (int i = 0; i < MST_NB; i++) begin
          if (!found && bus.i_awvalid[(m_ptr + i) % MST_NB]) begin
            found = 1'b1;
            g     = (m_ptr + i) % MST_NB;
          end
        end
      end
      e_awvalid = found && (q.size() < OSTD_NB);
      e_iar     = (e_awvalid && bus.o_awready) ? 4'(1 << g) : 4'h0;
      e_wvalid  = 1'b0;
      e_wlast   = 1'b0;
      e_iwr     = 4'h0;
      h         = 0;
      if (q.size() > 0) begin
        h        = q[0];
        e_wvalid = bus.i_wvalid[h];
        e_wlast  = bus.i_wlast[h];
        e_iwr    = bus.o_wready ? 4'(1 << h) : 4'h0;
      end
      checkOutput("rnd_awvalid", 32'(bus.o_awvalid), 32'(e_awvalid));
      checkOutput("rnd_iawready", 32'(bus.i_awready), 32'(e_iar));
      checkOutput("rnd_wvalid", 32'(bus.o_wvalid), 32'(e_wvalid));
      checkOutput("rnd_iwready", 32'(bus.i_wready), 32'(e_iwr));
      checkOutput("rnd_cnt", 32'(bus.o_ostd_cnt), 32'(q.size()));
      if (e_awvalid) checkOutput("rnd_awch", 32'(bus.o_awch), 32'(bus.i_awch[g*AWCH_W +: AWCH_W]));
      if (e_wvalid) begin
        checkOutput("rnd_wch", 32'(bus.o_wch), 32'(bus.i_wch[h*WCH_W +: WCH_W]));
        checkOutput("rnd_wlast", 32'(bus.o_wlast), 32'(e_wlast));
      end
      aw_hs = e_awvalid && bus.o_awready;
      pop   = e_wvalid && bus.o_wready && e_wlast;
      if (pop) void'(q.pop_front());
      if (aw_hs) begin
        q.push_back(g);
        m_ptr  = (g + 1) % MST_NB;
        m_lock = 1'b0;
      end else if (e_awvalid) begin
        m_lock     = 1'b1;
        m_lock_idx = g;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
